// File: rtl/io_bus_controller.sv
// Multi-channel IO bus controller: decodes a channel from the core address, runs a
// req/ack handshake with timeout, and stalls the core until the access completes.
module io_bus_controller #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int N_CH       = 4,
  parameter int CH_SEL_LSB = 28,
  parameter int TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        core_address,
  input  logic [DATA_W-1:0]        core_write_value,
  output logic [DATA_W-1:0]        core_read_value,
  input  logic                     core_write_en,
  input  logic                     core_read_en,
  output logic                     core_stall,
  output logic [N_CH-1:0]          ch_req,
  output logic                     ch_we,
  output logic [ADDR_W-1:0]        ch_addr,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [N_CH*DATA_W-1:0]   ch_rdata,
  input  logic [N_CH-1:0]          ch_ack,
  output logic                     err_timeout,
  output logic                     err_decode,
  input  logic                     err_clear
);

  localparam int          CW       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW:0] N_CH_L   = (CW+1)'(N_CH);
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CW-1:0]       r_sel;
  logic [7:0]          r_cnt;

  logic                w_start;
  logic [CW-1:0]       w_sel_in;
  logic                w_sel_ok;
  logic [N_CH-1:0]     w_sel_hit;
  logic                w_ack_sel;
  logic [DATA_W-1:0]   w_rdata_sel;
  logic                w_timeout;
  logic                w_set_decode;
  logic                w_set_timeout;

  assign w_start   = core_read_en | core_write_en;
  assign w_sel_in  = core_address[CH_SEL_LSB +: CW];
  assign w_sel_ok  = ({1'b0, w_sel_in} < N_CH_L);
  // r_cnt counts completed REQ cycles, so this is the TIMEOUT-th REQ cycle
  assign w_timeout = (r_cnt == CNT_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_sel_hit[gi] = (r_sel == CW'(gi));
    end
  endgenerate

  always_comb begin
    w_ack_sel   = 1'b0;
    w_rdata_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_sel_hit[k]) begin
        w_ack_sel   = ch_ack[k];
        w_rdata_sel = ch_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    core_stall   = 1'b0;
    ch_req       = '0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          core_stall   = 1'b1;
          w_state_next = w_sel_ok ? REQ : DONE;
        end
      end
      REQ: begin
        core_stall = 1'b1;
        ch_req     = w_sel_hit;
        if (w_ack_sel || w_timeout) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_set_decode  = (r_state == IDLE) && w_start && !w_sel_ok;
  assign w_set_timeout = (r_state == REQ) && !w_ack_sel && w_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel           <= '0;
      r_cnt           <= '0;
      ch_we           <= 1'b0;
      ch_addr         <= '0;
      ch_wdata        <= '0;
      core_read_value <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            ch_addr  <= core_address;
            ch_wdata <= core_write_value;
            ch_we    <= core_write_en;
            r_sel    <= w_sel_in;
            r_cnt    <= '0;
            if (!w_sel_ok && !core_write_en) begin
              core_read_value <= '0;
            end
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 8'd1;
          // An ack on the final allowed cycle still completes the access cleanly
          if (w_ack_sel) begin
            if (!ch_we) begin
              core_read_value <= w_rdata_sel;
            end
          end else if (w_timeout) begin
            if (!ch_we) begin
              core_read_value <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      err_decode  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_decode  <= w_set_decode  | (err_decode  & ~err_clear);
      err_timeout <= w_set_timeout | (err_timeout & ~err_clear);
    end
  end

endmodule
